line_cmd_sequencer: RTL and testbench
=====================================

# line_cmd_sequencer

Command front end for the VGA line-drawing datapath. It accepts line commands over a valid/ready handshake, loads the endpoints into the downstream `line_drawer`, and holds that drawer in load (`drw_reset`) while idle. It then qualifies exactly one frame-buffer write per drawn pixel and pulses `done` when the line is finished. Optionally it also runs a full-screen clear sweep. It sits between the user/command logic and the `line_drawer`/frame-buffer pair.

## Interface
Parameters:
- `SCREEN_W`, 640: horizontal pixel count.
- `SCREEN_H`, 480: vertical pixel count.
- `COLOR_W`, 1: pixel colour width.

Ports:
- `clk`  in  1: single clock.
- `reset`  in  1: asynchronous, active-high reset.
- `cmd_valid`  in  1: a command is presented.
- `cmd_ready`  out  1: the sequencer can accept a command.
- `cmd_x0`, `cmd_x1`  in  10: line endpoint x coordinates.
- `cmd_y0`, `cmd_y1`  in  9: line endpoint y coordinates.
- `cmd_color`  in  `COLOR_W`: colour for the whole command.
- `cmd_clear`  in  1: request a full-screen clear instead of a line.
- `drw_reset`  out  1: load strobe driven into the drawer's `reset`.
- `drw_x0`, `drw_x1`  out  10: registered endpoint x coordinates to the drawer.
- `drw_y0`, `drw_y1`  out  9: registered endpoint y coordinates to the drawer.
- `drw_x`  in  10: current pixel x from the drawer.
- `drw_y`  in  9: current pixel y from the drawer.
- `fb_we`  out  1: frame-buffer write enable.
- `fb_x`  out  10: frame-buffer write x.
- `fb_y`  out  9: frame-buffer write y.
- `fb_color`  out  `COLOR_W`: frame-buffer write colour.
- `done`  out  1: one-cycle pulse when a command completes.

## Operation
- States: IDLE, LOAD, DRAW, CLEAR, FIN.
- IDLE:
  - `cmd_ready`=1, `drw_reset`=1.
  - When `cmd_valid`&`cmd_ready`: latch endpoints into the `drw_*` registers and latch `cmd_color`.
  - Compute `len` = max(|x1−x0|, |y1−y0|) + 1, 10 bits unsigned, range 1..640.
  - Go to LOAD, or to CLEAR if `cmd_clear`=1 and clear is compiled in.
- LOAD:
  - One cycle, `drw_reset`=1.
  - The drawer samples the latched endpoints at the closing edge.
  - Go to DRAW.
- DRAW:
  - `drw_reset`=0, `fb_we`=1, `fb_x`/`fb_y` = `drw_x`/`drw_y` (combinational pass-through).
  - The down-counter starts at `len`. Leave for FIN when the counter reaches 1, so DRAW lasts exactly `len` cycles.
- CLEAR:
  - `fb_we`=1, `fb_x`/`fb_y` = sweep counters, raster order: x increments fastest and wraps from `SCREEN_W`−1 to 0 with y+1.
  - After (`SCREEN_W`−1, `SCREEN_H`−1), go to FIN.
  - `fb_color` = latched colour.
- FIN: one cycle, `done`=1, `fb_we`=0; go to IDLE.
- `cmd_ready` is 1 only in IDLE. Commands presented while busy are held by the producer and are not dropped.
- Degenerate line (x0=x1, y0=y1): `len`=1, exactly one write at (x0, y0).
- `fb_we`=0 in IDLE, LOAD and FIN. `fb_x`/`fb_y` are 0 outside DRAW and CLEAR.

## Timing
- Reset values:
  - State IDLE, `cmd_ready`=1, `drw_reset`=1.
  - `drw_x0`, `drw_x1`, `drw_y0`, `drw_y1` = 0.
  - `fb_we`=0, `fb_x`=0, `fb_y`=0, `fb_color`=0, `done`=0.
  - Counters 0.
- Reset asserted mid-DRAW or mid-CLEAR: the state returns to IDLE immediately (asynchronously), `fb_we` drops the same instant, and no `done` is issued.
- Line latency: accept edge → LOAD (1 cycle) → first write in the following cycle. Total command time is `len`+3 cycles from the accept edge to IDLE, with `done` in the cycle before IDLE.
- Clear time: `SCREEN_W`·`SCREEN_H` write cycles plus FIN.
- There is no frame-buffer backpressure. The drawer cannot stall, so writes are never throttled.

## Configuration
- `LINE_SEQ_CLEAR_EN` defined:
  - CLEAR state and sweep counters are present.
  - `cmd_clear`=1 starts a clear.
- `LINE_SEQ_CLEAR_EN` not defined:
  - CLEAR logic is absent.
  - `cmd_clear` is ignored and the command is drawn as a line from its endpoints.

## Structure
- Package `line_seq_pkg` holds:
  - the state enum;
  - `SCREEN_W`/`SCREEN_H` default constants;
  - typedefs `xcoord_t` (10 bit), `ycoord_t` (9 bit), `len_t` (10 bit).
- One sub-module, `screen_sweep`: an x/y raster counter with start, step and last outputs. It is instantiated only under `LINE_SEQ_CLEAR_EN`.
- The length/absolute-difference computation stays inline.

## Test plan
Each scenario is run with a real `line_drawer` instance connected.
- Horizontal line (0,3)→(15,3), colour 1:
  - `cmd_ready` falls after accept and `drw_reset` is high for the LOAD cycle.
  - 16 writes, x=0..15 with y=3.
  - `done` pulses once and `cmd_ready` returns after 19 cycles.
- Steep line (0,27)→(7,3):
  - exactly 25 writes, y spanning 3..27;
  - no write outside the DRAW window.
- Single point (5,5)→(5,5): one write at (5,5), then `done`.
- Back-to-back commands with `cmd_valid` held high:
  - the second command is accepted only in the IDLE cycle after `done`;
  - its endpoints reach `drw_*` intact.
- Reset pulse in the 4th DRAW cycle of a 16-pixel line:
  - `fb_we`=0 immediately, state IDLE, no `done`;
  - the next command then runs correctly.
- With `LINE_SEQ_CLEAR_EN`, SCREEN_W=8, SCREEN_H=4, `cmd_clear`=1:
  - 32 writes in raster order (0,0)…(7,3), then `done`.
  - Without the macro, the same command draws a line from its endpoints.

Source files
------------

// File: rtl/line_seq_pkg.sv
// Shared types and defaults for the line command sequencer.
package line_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DRAW,
    S_CLEAR,
    S_FIN
  } seq_state_t;

  localparam int SCREEN_W_DEF = 640;
  localparam int SCREEN_H_DEF = 480;

  typedef logic [9:0] xcoord_t;
  typedef logic [8:0] ycoord_t;
  typedef logic [9:0] len_t;

endpackage

// File: rtl/screen_sweep.sv
// Raster-order x/y counter for the full-screen clear: x fastest, then y.
module screen_sweep
  import line_seq_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    start,
  input  logic    step,
  output xcoord_t x,
  output ycoord_t y,
  output logic    last
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x <= '0;
      y <= '0;
    end else if (start) begin
      x <= '0;
      y <= '0;
    end else if (step) begin
      if (x == xcoord_t'(SCREEN_W - 1)) begin
        x <= '0;
        y <= (y == ycoord_t'(SCREEN_H - 1)) ? '0 : y + ycoord_t'(1);
      end else begin
        x <= x + xcoord_t'(1);
      end
    end
  end

  assign last = (x == xcoord_t'(SCREEN_W - 1)) && (y == ycoord_t'(SCREEN_H - 1));

endmodule

// File: rtl/line_cmd_sequencer.sv
// Line command front end: loads the line_drawer, qualifies one write per pixel, pulses done.
// Optional full-screen clear sweep is built when LINE_SEQ_CLEAR_EN is defined.
module line_cmd_sequencer
  import line_seq_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF,
  parameter int COLOR_W  = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [9:0]         cmd_x0,
  input  logic [9:0]         cmd_x1,
  input  logic [8:0]         cmd_y0,
  input  logic [8:0]         cmd_y1,
  input  logic [COLOR_W-1:0] cmd_color,
  input  logic               cmd_clear,
  output logic               drw_reset,
  output logic [9:0]         drw_x0,
  output logic [9:0]         drw_x1,
  output logic [8:0]         drw_y0,
  output logic [8:0]         drw_y1,
  input  logic [9:0]         drw_x,
  input  logic [8:0]         drw_y,
  output logic               fb_we,
  output logic [9:0]         fb_x,
  output logic [8:0]         fb_y,
  output logic [COLOR_W-1:0] fb_color,
  output logic               done
);

  function automatic len_t abs_diff(input logic signed [10:0] a, input logic signed [10:0] b);
    logic signed [10:0] d;
    d = b - a;
    return (d < 0) ? len_t'(-d) : len_t'(d);
  endfunction

  seq_state_t           state;
  len_t                 dx_p0, dy_p0, len_p0;
  len_t                 cnt_p1;
  logic [COLOR_W-1:0]   color_p1;
  logic                 accept;
  logic                 do_clear;
  logic                 sweep_last;

  assign accept = cmd_valid & cmd_ready;

  // Stage p0: line length from the presented endpoints
  assign dx_p0  = abs_diff($signed({1'b0, cmd_x0}), $signed({1'b0, cmd_x1}));
  assign dy_p0  = abs_diff($signed({2'b0, cmd_y0}), $signed({2'b0, cmd_y1}));
  assign len_p0 = ((dx_p0 > dy_p0) ? dx_p0 : dy_p0) + len_t'(1);

`ifdef LINE_SEQ_CLEAR_EN
  xcoord_t sweep_x;
  ycoord_t sweep_y;

  assign do_clear = cmd_clear;

  screen_sweep #(
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H)
  ) u_sweep (
    .clk   (clk),
    .reset (reset),
    .start (accept & do_clear),
    .step  (state == S_CLEAR),
    .x     (sweep_x),
    .y     (sweep_y),
    .last  (sweep_last)
  );
`else
  localparam int unused_screen_px = SCREEN_W * SCREEN_H;
  logic unused_clear;

  assign unused_clear = cmd_clear;
  assign do_clear     = 1'b0;
  assign sweep_last   = 1'b0;
`endif

  // Stage p1: control FSM, latched endpoints and registered handshake/strobe outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cmd_ready <= 1'b1;
      drw_reset <= 1'b1;
      fb_we     <= 1'b0;
      done      <= 1'b0;
      drw_x0    <= '0;
      drw_x1    <= '0;
      drw_y0    <= '0;
      drw_y1    <= '0;
      color_p1  <= '0;
      cnt_p1    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            drw_x0    <= cmd_x0;
            drw_x1    <= cmd_x1;
            drw_y0    <= cmd_y0;
            drw_y1    <= cmd_y1;
            color_p1  <= cmd_color;
            cnt_p1    <= len_p0;
            cmd_ready <= 1'b0;
            if (do_clear) begin
              state <= S_CLEAR;
              fb_we <= 1'b1;
            end else begin
              state <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          state     <= S_DRAW;
          drw_reset <= 1'b0;
          fb_we     <= 1'b1;
        end
        S_DRAW: begin
          if (cnt_p1 == len_t'(1)) begin
            state <= S_FIN;
            fb_we <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt_p1 <= cnt_p1 - len_t'(1);
          end
        end
        S_CLEAR: begin
          if (sweep_last) begin
            state <= S_FIN;
            fb_we <= 1'b0;
            done  <= 1'b1;
          end
        end
        S_FIN: begin
          state     <= S_IDLE;
          done      <= 1'b0;
          cmd_ready <= 1'b1;
          drw_reset <= 1'b1;
        end
        default: begin
          state     <= S_IDLE;
          cmd_ready <= 1'b1;
          drw_reset <= 1'b1;
          fb_we     <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

  // Write address follows the drawer directly, so it is valid in the same cycle as fb_we
  always_comb begin
    fb_x = '0;
    fb_y = '0;
    if (state == S_DRAW) begin
      fb_x = drw_x;
      fb_y = drw_y;
    end
`ifdef LINE_SEQ_CLEAR_EN
    else if (state == S_CLEAR) begin
      fb_x = sweep_x;
      fb_y = sweep_y;
    end
`endif
  end

  assign fb_color = color_p1;

endmodule

// File: tb/tb_line_cmd_sequencer.sv
// Directed bench for line_cmd_sequencer with a Bresenham line_drawer model on the drw_* side.
module tb_line_cmd_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [9:0] cmd_x0 = '0, cmd_x1 = '0;
  logic [8:0] cmd_y0 = '0, cmd_y1 = '0;
  logic [0:0] cmd_color = '0;
  logic       cmd_clear = 1'b0;
  logic       drw_reset;
  logic [9:0] drw_x0, drw_x1;
  logic [8:0] drw_y0, drw_y1;
  logic [9:0] drw_x;
  logic [8:0] drw_y;
  logic       fb_we;
  logic [9:0] fb_x;
  logic [8:0] fb_y;
  logic [0:0] fb_color;
  logic       done;

  int compared = 0;
  int mismatched = 0;

  logic [9:0] wx_q[$];
  logic [8:0] wy_q[$];
  int         wk_q[$];
  logic [0:0] wc_q[$];

  always #5 clk = ~clk;

  line_cmd_sequencer #(.SCREEN_W(8), .SCREEN_H(4), .COLOR_W(1)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x0(cmd_x0), .cmd_x1(cmd_x1), .cmd_y0(cmd_y0), .cmd_y1(cmd_y1),
    .cmd_color(cmd_color), .cmd_clear(cmd_clear),
    .drw_reset(drw_reset),
    .drw_x0(drw_x0), .drw_x1(drw_x1), .drw_y0(drw_y0), .drw_y1(drw_y1),
    .drw_x(drw_x), .drw_y(drw_y),
    .fb_we(fb_we), .fb_x(fb_x), .fb_y(fb_y), .fb_color(fb_color),
    .done(done)
  );

  // Bresenham line_drawer model: loads endpoints while its reset is high, steps one pixel per clock otherwise
  logic [9:0] mx;
  logic [8:0] my;
  int merr, mdx, mdy, msx, msy, e2;

  always_comb begin
    mdx = (drw_x1 >= drw_x0) ? int'(drw_x1) - int'(drw_x0) : int'(drw_x0) - int'(drw_x1);
    mdy = (drw_y1 >= drw_y0) ? int'(drw_y0) - int'(drw_y1) : int'(drw_y1) - int'(drw_y0);
    msx = (drw_x1 >= drw_x0) ? 1 : -1;
    msy = (drw_y1 >= drw_y0) ? 1 : -1;
    e2  = 2 * merr;
  end

  always @(posedge clk) begin
    if (drw_reset) begin
      mx   <= drw_x0;
      my   <= drw_y0;
      merr <= mdx + mdy;
    end else if (e2 >= mdy && e2 <= mdx) begin
      merr <= merr + mdy + mdx;
      mx   <= 10'(int'(mx) + msx);
      my   <= 9'(int'(my) + msy);
    end else if (e2 >= mdy) begin
      merr <= merr + mdy;
      mx   <= 10'(int'(mx) + msx);
    end else if (e2 <= mdx) begin
      merr <= merr + mdx;
      my   <= 9'(int'(my) + msy);
    end
  end

  assign drw_x = mx;
  assign drw_y = my;

  // Issues one command and logs writes; k counts sampled cycles after the accepting edge (LOAD is k=1)
  task automatic run_cmd(input logic [9:0] x0, input logic [8:0] y0, input logic [9:0] x1,
                         input logic [8:0] y1, input logic c, input logic clr, input int budget,
                         output int done_at, output int done_n, output int ready_at,
                         output logic ld_ready, output logic ld_drw_reset);
    int w;
    wx_q.delete(); wy_q.delete(); wk_q.delete(); wc_q.delete();
    done_at = -1; done_n = 0; ready_at = -1; ld_ready = 1'b1; ld_drw_reset = 1'b0;
    @(negedge clk);
    cmd_x0 = x0; cmd_y0 = y0; cmd_x1 = x1; cmd_y1 = y1;
    cmd_color = c; cmd_clear = clr; cmd_valid = 1'b1;
    w = 0;
    while (!cmd_ready && w < budget) begin
      @(negedge clk);
      w++;
    end
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (k == 1) begin
        ld_ready = cmd_ready;
        ld_drw_reset = drw_reset;
        cmd_valid = 1'b0;
      end
      if (fb_we) begin
        wx_q.push_back(fb_x); wy_q.push_back(fb_y); wk_q.push_back(k); wc_q.push_back(fb_color);
      end
      if (done) begin
        done_n++;
        done_at = k;
      end
      if (cmd_ready) begin
        ready_at = k;
        break;
      end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    compared++; if (cmd_ready !== 1'b1) begin mismatched++; $display("FAIL rst_cmd_ready: got %b want 1", cmd_ready); end
    compared++; if (drw_reset !== 1'b1) begin mismatched++; $display("FAIL rst_drw_reset: got %b want 1", drw_reset); end
    compared++; if ({drw_x0, drw_x1, drw_y0, drw_y1} !== 38'd0) begin mismatched++; $display("FAIL rst_drw_ends: got %h want 0", {drw_x0, drw_x1, drw_y0, drw_y1}); end
    compared++; if ({fb_we, fb_x, fb_y, fb_color, done} !== 22'd0) begin mismatched++; $display("FAIL rst_fb: got %h want 0", {fb_we, fb_x, fb_y, fb_color, done}); end
  endtask

  task automatic test_horizontal;
    int da, dn, ra;
    logic lr, ld;
    int bad;
    run_cmd(10'd0, 9'd3, 10'd15, 9'd3, 1'b1, 1'b0, 60, da, dn, ra, lr, ld);
    compared++; if (lr !== 1'b0) begin mismatched++; $display("FAIL horiz_ready_low_in_load: got %b want 0", lr); end
    compared++; if (ld !== 1'b1) begin mismatched++; $display("FAIL horiz_drw_reset_in_load: got %b want 1", ld); end
    compared++; if (wx_q.size() !== 16) begin mismatched++; $display("FAIL horiz_write_count: got %0d want 16", wx_q.size()); end
    bad = 0;
    for (int i = 0; i < wx_q.size(); i++)
      if (wx_q[i] !== 10'(i) || wy_q[i] !== 9'd3 || wk_q[i] !== i + 2 || wc_q[i] !== 1'b1) bad++;
    compared++; if (bad !== 0) begin mismatched++; $display("FAIL horiz_pixels: got %0d bad writes want 0", bad); end
    compared++; if (dn !== 1) begin mismatched++; $display("FAIL horiz_done_count: got %0d want 1", dn); end
    compared++; if (da !== 18) begin mismatched++; $display("FAIL horiz_done_cycle: got %0d want 18", da); end
    compared++; if (ra !== 19) begin mismatched++; $display("FAIL horiz_ready_cycle: got %0d want 19", ra); end
  endtask

  task automatic test_steep;
    int da, dn, ra, ymin, ymax, outside;
    logic lr, ld;
    run_cmd(10'd0, 9'd27, 10'd7, 9'd3, 1'b1, 1'b0, 80, da, dn, ra, lr, ld);
    compared++; if (wx_q.size() !== 25) begin mismatched++; $display("FAIL steep_write_count: got %0d want 25", wx_q.size()); end
    ymin = 999; ymax = -1; outside = 0;
    for (int i = 0; i < wy_q.size(); i++) begin
      if (int'(wy_q[i]) < ymin) ymin = int'(wy_q[i]);
      if (int'(wy_q[i]) > ymax) ymax = int'(wy_q[i]);
      if (wk_q[i] < 2 || wk_q[i] > 26) outside++;
    end
    compared++; if (ymin !== 3 || ymax !== 27) begin mismatched++; $display("FAIL steep_y_span: got %0d..%0d want 3..27", ymin, ymax); end
    compared++; if (outside !== 0) begin mismatched++; $display("FAIL steep_write_window: got %0d outside want 0", outside); end
    if (wx_q.size() > 0) begin
      compared++; if ({wx_q[0], wy_q[0]} !== {10'd0, 9'd27}) begin mismatched++; $display("FAIL steep_first: got (%0d,%0d) want (0,27)", wx_q[0], wy_q[0]); end
      compared++; if ({wx_q[$], wy_q[$]} !== {10'd7, 9'd3}) begin mismatched++; $display("FAIL steep_last: got (%0d,%0d) want (7,3)", wx_q[$], wy_q[$]); end
    end
    compared++; if (dn !== 1 || da !== 27) begin mismatched++; $display("FAIL steep_done: got n=%0d at %0d want n=1 at 27", dn, da); end
  endtask

  task automatic test_single_point;
    int da, dn, ra;
    logic lr, ld;
    run_cmd(10'd5, 9'd5, 10'd5, 9'd5, 1'b0, 1'b0, 30, da, dn, ra, lr, ld);
    compared++; if (wx_q.size() !== 1) begin mismatched++; $display("FAIL point_write_count: got %0d want 1", wx_q.size()); end
    if (wx_q.size() > 0) begin
      compared++; if ({wx_q[0], wy_q[0], wk_q[0]} !== {10'd5, 9'd5, 32'd2}) begin mismatched++; $display("FAIL point_write: got (%0d,%0d)@%0d want (5,5)@2", wx_q[0], wy_q[0], wk_q[0]); end
    end
    compared++; if (dn !== 1 || da !== 3 || ra !== 4) begin mismatched++; $display("FAIL point_done: got n=%0d done@%0d ready@%0d want 1,3,4", dn, da, ra); end
  endtask

  task automatic test_back_to_back;
    int k, da, ra, w, rb;
    // A = (2,1)->(4,1), len 3; B = (9,8)->(1,2), len 9
    @(negedge clk);
    cmd_x0 = 10'd2; cmd_y0 = 9'd1; cmd_x1 = 10'd4; cmd_y1 = 9'd1; cmd_color = 1'b1; cmd_clear = 1'b0;
    cmd_valid = 1'b1;
    w = 0;
    while (!cmd_ready && w < 20) begin @(negedge clk); w++; end
    da = -1; ra = -1;
    for (k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 1) begin cmd_x0 = 10'd9; cmd_y0 = 9'd8; cmd_x1 = 10'd1; cmd_y1 = 9'd2; cmd_color = 1'b0; end
      if (done) da = k;
      if (cmd_ready) begin ra = k; break; end
    end
    compared++; if (da !== 5 || ra !== 6) begin mismatched++; $display("FAIL b2b_first_timing: got done@%0d ready@%0d want 5,6", da, ra); end
    compared++; if ({drw_x0, drw_y0, drw_x1, drw_y1} !== {10'd2, 9'd1, 10'd4, 9'd1}) begin mismatched++; $display("FAIL b2b_held_before_accept: got %h", {drw_x0, drw_y0, drw_x1, drw_y1}); end
    @(negedge clk);
    cmd_valid = 1'b0;
    compared++; if (cmd_ready !== 1'b0) begin mismatched++; $display("FAIL b2b_second_accept: got ready %b want 0", cmd_ready); end
    compared++; if ({drw_x0, drw_y0, drw_x1, drw_y1} !== {10'd9, 9'd8, 10'd1, 9'd2}) begin mismatched++; $display("FAIL b2b_second_ends: got %h want %h", {drw_x0, drw_y0, drw_x1, drw_y1}, {10'd9, 9'd8, 10'd1, 9'd2}); end
    rb = -1;
    for (k = 2; k <= 40; k++) begin
      @(negedge clk);
      if (cmd_ready) begin rb = k; break; end
    end
    compared++; if (rb !== 12) begin mismatched++; $display("FAIL b2b_second_ready: got %0d want 12", rb); end
  endtask

  task automatic test_reset_mid_draw;
    int w, ndone, nwe, da, dn, ra;
    logic lr, ld;
    @(negedge clk);
    cmd_x0 = 10'd0; cmd_y0 = 9'd3; cmd_x1 = 10'd15; cmd_y1 = 9'd3; cmd_color = 1'b1; cmd_clear = 1'b0;
    cmd_valid = 1'b1;
    w = 0;
    while (!cmd_ready && w < 20) begin @(negedge clk); w++; end
    repeat (5) @(negedge clk);
    cmd_valid = 1'b0;
    compared++; if (fb_we !== 1'b1 || fb_x !== 10'd3) begin mismatched++; $display("FAIL rstmid_4th_draw: got we=%b x=%0d want 1,3", fb_we, fb_x); end
    reset = 1'b1;
    #1;
    compared++; if (fb_we !== 1'b0) begin mismatched++; $display("FAIL rstmid_we_drop: got %b want 0", fb_we); end
    compared++; if ({cmd_ready, drw_reset, fb_x, fb_y, done} !== {1'b1, 1'b1, 10'd0, 9'd0, 1'b0}) begin mismatched++; $display("FAIL rstmid_idle: got %h", {cmd_ready, drw_reset, fb_x, fb_y, done}); end
    ndone = 0; nwe = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) reset = 1'b0;
      if (done) ndone++;
      if (fb_we) nwe++;
    end
    compared++; if (ndone !== 0 || nwe !== 0) begin mismatched++; $display("FAIL rstmid_quiet: got done=%0d we=%0d want 0,0", ndone, nwe); end
    run_cmd(10'd3, 9'd0, 10'd3, 9'd4, 1'b1, 1'b0, 40, da, dn, ra, lr, ld);
    compared++; if (wx_q.size() !== 5) begin mismatched++; $display("FAIL rstmid_next_count: got %0d want 5", wx_q.size()); end
    if (wx_q.size() == 5) begin
      compared++; if ({wx_q[0], wy_q[0], wx_q[4], wy_q[4]} !== {10'd3, 9'd0, 10'd3, 9'd4}) begin mismatched++; $display("FAIL rstmid_next_ends: got (%0d,%0d)-(%0d,%0d) want (3,0)-(3,4)", wx_q[0], wy_q[0], wx_q[4], wy_q[4]); end
    end
    compared++; if (dn !== 1 || ra !== 8) begin mismatched++; $display("FAIL rstmid_next_done: got n=%0d ready@%0d want 1,8", dn, ra); end
  endtask

  task automatic test_clear;
    int da, dn, ra, bad;
    logic lr, ld;
    run_cmd(10'd1, 9'd1, 10'd3, 9'd2, 1'b1, 1'b1, 80, da, dn, ra, lr, ld);
`ifdef LINE_SEQ_CLEAR_EN
    compared++; if (wx_q.size() !== 32) begin mismatched++; $display("FAIL clear_write_count: got %0d want 32", wx_q.size()); end
    bad = 0;
    for (int i = 0; i < wx_q.size(); i++)
      if (wx_q[i] !== 10'(i % 8) || wy_q[i] !== 9'(i / 8) || wk_q[i] !== i + 1 || wc_q[i] !== 1'b1) bad++;
    compared++; if (bad !== 0) begin mismatched++; $display("FAIL clear_raster: got %0d bad writes want 0", bad); end
    compared++; if (dn !== 1 || da !== 33 || ra !== 34) begin mismatched++; $display("FAIL clear_done: got n=%0d done@%0d ready@%0d want 1,33,34", dn, da, ra); end
`else
    // Bresenham (1,1)->(3,2) visits (1,1),(2,2),(3,2)
    bad = 0;
    compared++; if (wx_q.size() !== 3) begin mismatched++; $display("FAIL noclear_write_count: got %0d want 3", wx_q.size()); end
    if (wx_q.size() == 3) begin
      if ({wx_q[0], wy_q[0]} !== {10'd1, 9'd1}) bad++;
      if ({wx_q[1], wy_q[1]} !== {10'd2, 9'd2}) bad++;
      if ({wx_q[2], wy_q[2]} !== {10'd3, 9'd2}) bad++;
      compared++; if (bad !== 0) begin mismatched++; $display("FAIL noclear_pixels: got %0d bad want 0", bad); end
    end
    compared++; if (dn !== 1 || ra !== 6) begin mismatched++; $display("FAIL noclear_done: got n=%0d ready@%0d want 1,6", dn, ra); end
`endif
  endtask

  initial begin
    test_reset();
    test_horizontal();
    test_steep();
    test_single_point();
    test_back_to_back();
    test_reset_mid_draw();
    test_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
